// File: rtl/sevenseg_mux.sv
// Multiplexed common-anode seven-segment driver. Incoming BCD is double-buffered
// and reaches the display only at a frame boundary. Adds leading-zero blanking,
// per-digit decimal points and an anti-ghosting blank at the start of each slot.
module sevenseg_mux #(
  parameter int DIGITS         = 8,
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int BLANK_CLKS     = 1000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DIGITS*4-1:0]   BCD,
  input  logic                  BCD_VALID,
  input  logic [DIGITS-1:0]     DP_MASK,
  input  logic                  LZ_BLANK,
  output logic [DIGITS-1:0]     ANODE,
  output logic [7:0]            CATHODE
);

  localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CLKS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic [DIGITS*4-1:0] shadow_bcd, active_bcd;
  logic [DIGITS-1:0]   shadow_dp, active_dp;
  logic                pending;

  logic                slot_wrap, frame_wrap, blank_now;
  logic [3:0]          nyb;
  logic                dp_on, lz_hit, run_zero;
  logic [DIGITS-1:0]   upper_zero;
  logic [7:0]          seg_full;

  assign slot_wrap  = (slot_cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (digit_idx == IDX_LAST);
  assign blank_now  = (slot_cnt < BLANK_END);

  // upper_zero[i]: active nybbles i..DIGITS-1 are all zero
  always_comb begin
    run_zero   = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero      = run_zero & (active_bcd[i*4 +: 4] == 4'd0);
      upper_zero[i] = run_zero;
    end
  end

  always_comb begin
    nyb    = 4'd0;
    dp_on  = 1'b0;
    lz_hit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        nyb    = active_bcd[i*4 +: 4];
        dp_on  = active_dp[i];
        lz_hit = upper_zero[i] && (i != 0);
      end
    end
  end

  always_comb begin
    seg_full = 8'hBF;
    case (nyb)
      4'd0:    seg_full = 8'hC0;
      4'd1:    seg_full = 8'hF9;
      4'd2:    seg_full = 8'hA4;
      4'd3:    seg_full = 8'hB0;
      4'd4:    seg_full = 8'h99;
      4'd5:    seg_full = 8'h92;
      4'd6:    seg_full = 8'h82;
      4'd7:    seg_full = 8'hF8;
      4'd8:    seg_full = 8'h80;
      4'd9:    seg_full = 8'h90;
      default: seg_full = 8'hBF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      active_bcd <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      ANODE      <= '1;
      CATHODE    <= 8'hFF;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap)
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;

      // Transfer takes the old shadow; a strobe on the same edge stays pending.
      if (frame_wrap && pending) begin
        active_bcd <= shadow_bcd;
        active_dp  <= shadow_dp;
        pending    <= 1'b0;
      end
      if (BCD_VALID) begin
        shadow_bcd <= BCD;
        shadow_dp  <= DP_MASK;
        pending    <= 1'b1;
      end

      if (blank_now) begin
        ANODE   <= '1;
        CATHODE <= 8'hFF;
      end else begin
        ANODE   <= ~(DIGITS'(1) << digit_idx);
        CATHODE <= {~dp_on, (LZ_BLANK && lz_hit) ? 7'h7F : seg_full[6:0]};
      end
    end
  end

endmodule
